// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch (IF), load/store (DM) and memory-macro signals of the
// unified memory port arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            valids, read data and the memory command)
//   master : environment view (CPU datapath + memory macro)
// Parameters: AW address width, DW data width.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Instruction-fetch side
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    // Load/store side
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;
    // Memory macro side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the CPU fetch path (IF) and the
// load/store path (DM). One access is outstanding at a time:
// IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE. All outputs are registered.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : mem_port_arbiter_if.slave (IF/DM req/gnt/valid handshakes and
//           the memory command/read-data bus)
// Parameters: AW, DW widths; MEM_LAT memory read latency (>= 1), counted
//   from the mem_en cycle to the cycle mem_rdata is valid.
// Build option: define DM_PRIORITY_EN for fixed DM-wins-ties priority;
//   default is round-robin tie-break on the last owner.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned LatW = $clog2(MEM_LAT + 1);
    localparam logic OwnIf = 1'b0;
    localparam logic OwnDm = 1'b1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic            r_owner, w_owner_nxt;
    logic            r_last_owner, w_last_owner_nxt;
    logic [LatW-1:0] r_lat_cnt, w_lat_cnt_nxt;
    logic            r_mem_en, w_mem_en_nxt;
    logic            r_mem_we, w_mem_we_nxt;
    logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic            r_if_gnt, w_if_gnt_nxt;
    logic            r_if_valid, w_if_valid_nxt;
    logic [DW-1:0]   r_if_rdata, w_if_rdata_nxt;
    logic            r_dm_gnt, w_dm_gnt_nxt;
    logic            r_dm_valid, w_dm_valid_nxt;
    logic [DW-1:0]   r_dm_rdata, w_dm_rdata_nxt;
    logic            w_win_dm;

`ifdef DM_PRIORITY_EN
    assign w_win_dm = bus.dm_req;
`else
    // On a tie the side that did not own the previous access wins.
    assign w_win_dm = bus.dm_req & (~bus.if_req | (r_last_owner == OwnIf));
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_lat_cnt_nxt    = r_lat_cnt;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_if_gnt_nxt     = 1'b0;
        w_if_valid_nxt   = 1'b0;
        w_if_rdata_nxt   = r_if_rdata;
        w_dm_gnt_nxt     = 1'b0;
        w_dm_valid_nxt   = 1'b0;
        w_dm_rdata_nxt   = r_dm_rdata;

        unique case (r_state)
            StIdle: begin
                // Command outputs are loaded here so they are live during ISSUE.
                if (bus.if_req || bus.dm_req) begin
                    w_state_nxt  = StIssue;
                    w_owner_nxt  = w_win_dm ? OwnDm : OwnIf;
                    w_mem_en_nxt = 1'b1;
                    if (w_win_dm) begin
                        w_mem_we_nxt    = bus.dm_we;
                        w_mem_addr_nxt  = bus.dm_addr;
                        w_mem_wdata_nxt = bus.dm_wdata;
                        w_dm_gnt_nxt    = 1'b1;
                    end else begin
                        w_mem_addr_nxt  = bus.if_addr;
                        w_if_gnt_nxt    = 1'b1;
                    end
                end
            end
            StIssue: begin
                w_last_owner_nxt = r_owner;
                if (r_mem_we) begin
                    // Only DM can store; completion is immediate.
                    w_state_nxt    = StDone;
                    w_dm_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt   = StWait;
                    w_lat_cnt_nxt = LatW'(MEM_LAT - 1);
                end
            end
            StWait: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = StDone;
                    if (r_owner == OwnDm) begin
                        w_dm_rdata_nxt = bus.mem_rdata;
                        w_dm_valid_nxt = 1'b1;
                    end else begin
                        w_if_rdata_nxt = bus.mem_rdata;
                        w_if_valid_nxt = 1'b1;
                    end
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_owner      <= OwnIf;
            r_last_owner <= OwnDm;
            r_lat_cnt    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_gnt     <= 1'b0;
            r_if_valid   <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_gnt     <= 1'b0;
            r_dm_valid   <= 1'b0;
            r_dm_rdata   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_if_gnt     <= w_if_gnt_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_dm_gnt     <= w_dm_gnt_nxt;
            r_dm_valid   <= w_dm_valid_nxt;
            r_dm_rdata   <= w_dm_rdata_nxt;
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_gnt    = r_dm_gnt;
    assign bus.dm_valid  = r_dm_valid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule
